// File: rtl/seq_pkg.sv
// seq_pkg: shared state type, default widths and the count increment helper
package seq_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_ERR_WIDTH = 16;
  typedef enum logic {UNLOCKED, LOCKED} seq_state_t;
  // Wide increment; callers truncate to their own width, giving modulo-2^W wrap
  function automatic logic [63:0] next_count(input logic [63:0] x);
    return x + 64'd1;
  endfunction
endpackage

// File: rtl/seq_checker_if.sv
// seq_checker_if: count stream input and checker status outputs
interface seq_checker_if import seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERR_WIDTH = DEF_ERR_WIDTH
);
  logic in_valid;
  logic [WIDTH-1:0] in_data;
  logic locked;
  logic err;
  logic [ERR_WIDTH-1:0] err_count;
  logic [WIDTH-1:0] expected;
  modport master (output in_valid, in_data, input locked, err, err_count, expected);
  modport slave (input in_valid, in_data, output locked, err, err_count, expected);
endinterface

// File: rtl/seq_sat_counter.sv
// seq_sat_counter: enabled up-counter with synchronous clear, holds at all-ones
module seq_sat_counter #(
  parameter int N = 16
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_en,
  output logic [N-1:0] o_q
);
  logic [N-1:0] r_q;
  always_ff @(posedge clk) begin
    if (i_clr) r_q <= '0;
    else if (i_en && !(&r_q)) r_q <= r_q + 1'b1;
  end
  assign o_q = r_q;
endmodule

// File: rtl/seq_checker.sv
// seq_checker: locks onto a +1 count stream and flags mismatching words while locked
module seq_checker import seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_WIDTH = DEF_ERR_WIDTH
) (
  input logic clk,
  input logic rst,
  seq_checker_if.slave bus
);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);
  localparam logic [RW-1:0] LC = RW'(LOCK_COUNT);
  localparam logic [MW-1:0] LS = MW'(LOSS_COUNT);
  seq_state_t r_state, w_state;
  logic [WIDTH-1:0] r_prev, w_prev, r_exp, w_exp;
  logic r_have, w_have, r_err, w_err;
  logic [RW-1:0] r_run, w_run;
  logic [MW-1:0] r_miss, w_miss;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= UNLOCKED;
      r_prev <= '0;
      r_exp <= '0;
      r_have <= 1'b0;
      r_err <= 1'b0;
      r_run <= '0;
      r_miss <= '0;
    end else begin
      r_state <= w_state;
      r_prev <= w_prev;
      r_exp <= w_exp;
      r_have <= w_have;
      r_err <= w_err;
      r_run <= w_run;
      r_miss <= w_miss;
    end
  end
  always_comb begin
    w_state = r_state;
    w_prev = r_prev;
    w_exp = r_exp;
    w_have = r_have;
    w_err = 1'b0;
    w_run = r_run;
    w_miss = r_miss;
    if (bus.in_valid && r_state == UNLOCKED) begin
      w_run = (r_have && bus.in_data == WIDTH'(next_count(64'(r_prev)))) ? r_run + 1'b1 : '0;
      w_prev = bus.in_data;
      w_have = 1'b1;
      if (w_run == LC) begin
        w_state = LOCKED;
        w_exp = WIDTH'(next_count(64'(bus.in_data)));
        w_miss = '0;
      end
    end else if (bus.in_valid) begin
      // Flywheel: expected always advances, a bad word is never adopted
      w_exp = WIDTH'(next_count(64'(r_exp)));
      w_err = bus.in_data != r_exp;
      w_miss = w_err ? r_miss + 1'b1 : '0;
      if (w_err && w_miss == LS) begin
        w_state = UNLOCKED;
        w_run = '0;
        w_prev = bus.in_data;
        w_have = 1'b1;
      end
    end
  end
  seq_sat_counter #(.N(ERR_WIDTH)) u_err_cnt (
    .clk(clk),
    .i_clr(rst),
    .i_en(w_err && !rst),
    .o_q(bus.err_count)
  );
  assign bus.locked = r_state == LOCKED;
  assign bus.err = r_err;
  assign bus.expected = r_exp;
endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: scoreboard bench for two seq_checker configurations driven by one stream
module tb_seq_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_checker_if #(.WIDTH(8), .ERR_WIDTH(16)) b0 ();
  seq_checker_if #(.WIDTH(8), .ERR_WIDTH(2)) b1 ();
  seq_checker #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_WIDTH(16)) d0 (.clk(clk), .rst(rst), .bus(b0));
  seq_checker #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(8), .ERR_WIDTH(2)) d1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    int l;
    int e;
    int c;
    int x;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int errors = 0;
  int checks = 0;

  // Reference model state, one slot per DUT configuration
  int lc[2] = '{4, 4};
  int ls[2] = '{3, 8};
  int ew[2] = '{16, 2};
  int m_lock[2], m_prev[2], m_have[2], m_run[2], m_miss[2], m_exp[2], m_cnt[2], m_err[2];

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model(int k, bit r, bit v, int d);
    if (r) begin
      m_lock[k] = 0; m_prev[k] = 0; m_have[k] = 0; m_run[k] = 0;
      m_miss[k] = 0; m_exp[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
      return;
    end
    m_err[k] = 0;
    if (!v) return;
    if (m_lock[k] == 0) begin
      m_run[k] = (m_have[k] != 0 && d == (m_prev[k] + 1) % 256) ? m_run[k] + 1 : 0;
      m_prev[k] = d;
      m_have[k] = 1;
      if (m_run[k] == lc[k]) begin
        m_lock[k] = 1;
        m_exp[k] = (d + 1) % 256;
        m_miss[k] = 0;
      end
    end else begin
      if (d == m_exp[k]) m_miss[k] = 0;
      else begin
        m_err[k] = 1;
        if (m_cnt[k] < (1 << ew[k]) - 1) m_cnt[k]++;
        m_miss[k]++;
        if (m_miss[k] == ls[k]) begin
          m_lock[k] = 0;
          m_run[k] = 0;
          m_prev[k] = d;
          m_have[k] = 1;
        end
      end
      m_exp[k] = (m_exp[k] + 1) % 256;
    end
  endtask

  function automatic exp_t snap(int k);
    exp_t e;
    e.l = m_lock[k]; e.e = m_err[k]; e.c = m_cnt[k]; e.x = m_exp[k];
    return e;
  endfunction

  task automatic step(bit r, bit v, int d);
    rst = r;
    b0.in_valid = v; b0.in_data = 8'(d);
    b1.in_valid = v; b1.in_data = 8'(d);
    @(posedge clk);
    model(0, r, v, d);
    model(1, r, v, d);
    q0.push_back(snap(0));
    q1.push_back(snap(1));
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("d0.locked", int'(b0.locked), e.l);
      chk("d0.err", int'(b0.err), e.e);
      chk("d0.err_count", int'(b0.err_count), e.c);
      chk("d0.expected", int'(b0.expected), e.x);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("d1.locked", int'(b1.locked), e.l);
      chk("d1.err", int'(b1.err), e.e);
      chk("d1.err_count", int'(b1.err_count), e.c);
      chk("d1.expected", int'(b1.expected), e.x);
    end
  end

  initial begin
    int d;
    b0.in_valid = 1'b0; b0.in_data = '0;
    b1.in_valid = 1'b0; b1.in_data = '0;
    step(1, 0, 0);
    chk("reset.locked", int'(b0.locked), 0);
    chk("reset.expected", int'(b0.expected), 0);
    // Lock-on from 10
    for (int i = 10; i <= 13; i++) begin
      step(0, 1, i);
      chk("prelock.locked", int'(b0.locked), 0);
    end
    step(0, 1, 14);
    chk("lock5.locked", int'(b0.locked), 1);
    chk("lock5.expected", int'(b0.expected), 15);
    for (int i = 15; i <= 17; i++) step(0, 1, i);
    chk("t1.err_count", int'(b0.err_count), 0);
    // Walk up through the wrap point
    for (int i = 18; i <= 258; i++) step(0, 1, i % 256);
    chk("wrap.expected", int'(b0.expected), 3);
    chk("wrap.err_count", int'(b0.err_count), 0);
    // Single bad word
    for (int i = 3; i <= 40; i++) step(0, 1, i);
    step(0, 1, 99);
    chk("bad.err", int'(b0.err), 1);
    step(0, 1, 42);
    chk("bad.err_after", int'(b0.err), 0);
    step(0, 1, 43);
    chk("bad.err_count", int'(b0.err_count), 1);
    chk("bad.locked", int'(b0.locked), 1);
    chk("bad.expected", int'(b0.expected), 44);
    // Three misses force unlock, then relock from 7
    step(0, 1, 7); step(0, 1, 7);
    chk("loss.locked_mid", int'(b0.locked), 1);
    step(0, 1, 7);
    chk("loss.locked", int'(b0.locked), 0);
    chk("loss.err", int'(b0.err), 1);
    chk("loss.err_count", int'(b0.err_count), 4);
    for (int i = 8; i <= 10; i++) step(0, 1, i);
    chk("relock.early", int'(b0.locked), 0);
    step(0, 1, 11);
    chk("relock.locked", int'(b0.locked), 1);
    chk("relock.expected", int'(b0.expected), 12);
    // Gapped valid
    for (int i = 12; i <= 19; i++) step(0, 1, i);
    for (int i = 20; i <= 22; i++) begin
      step(0, 1, i);
      step(0, 0, $urandom_range(0, 255));
      chk("gap.expected", int'(b0.expected), i + 1);
    end
    chk("gap.err_count", int'(b0.err_count), 4);
    // Saturate the 2-bit counter, then reset with a valid word pending
    for (int i = 0; i < 5; i++) step(0, 1, 200);
    chk("sat.err_count", int'(b1.err_count), 3);
    step(1, 1, 24);
    chk("rst.d1.err_count", int'(b1.err_count), 0);
    chk("rst.d1.locked", int'(b1.locked), 0);
    chk("rst.d0.expected", int'(b0.expected), 0);
    // Random stream: mostly increments, some jumps, gaps and rare resets
    d = $urandom_range(0, 255);
    for (int i = 0; i < 1500; i++) begin
      int p = $urandom_range(0, 99);
      if (p < 12) d = $urandom_range(0, 255);
      else d = (d + 1) % 256;
      step(p == 99, $urandom_range(0, 3) != 0, d);
    end
    @(negedge clk);
    #1;
    chk("drain", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
